// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined floating-point add/subtract block.
package fp_pkg;

    localparam int MAX_FW = 64;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inx;
        logic inv;
    } fp_flags_t;

    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_NAN  = 2'd1,
        SP_INF  = 2'd2,
        SP_ZERO = 2'd3
    } sp_kind_e;

    // Canonical quiet NaN {0, all-ones exponent, mantissa MSB set} for any format up to MAX_FW bits.
    function automatic logic [MAX_FW-1:0] fp_qnan(input int exp_w, input int man_w);
        logic [MAX_FW-1:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w+i] = 1'b1;
        end
        v[man_w-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametric combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
    parameter int WIDTH = 27,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CW-1:0]    count_o
);

    logic [CW-1:0] cnt_s;

    // Scan upward so the highest set bit is the one that sticks.
    always_comb begin
        cnt_s = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            cnt_s = data_i[i] ? CW'(WIDTH - 1 - i) : cnt_s;
        end
        count_o = cnt_s;
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point adder/subtractor: align, add, normalise/round/pack,
// with valid/ready flow control, flush-to-zero and round-to-nearest-even.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [EXP_W+MAN_W:0]     a_i,
    input  logic [EXP_W+MAN_W:0]     b_i,
    input  logic                     op_i,
    input  logic [TAG_W-1:0]         in_tag_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [EXP_W+MAN_W:0]     r_o,
    output logic [TAG_W-1:0]         out_tag_o,
    output logic                     overflow_o,
    output logic                     underflow_o,
    output logic                     inexact_o,
    output logic                     invalid_o
);

    localparam int FW  = 1 + EXP_W + MAN_W;
    localparam int W   = MAN_W + 4;
    localparam int LZW = $clog2(W + 1);
    localparam int EW  = EXP_W + LZW + 2;
    localparam logic [MAX_FW-1:0]    QNAN_FULL = fp_qnan(EXP_W, MAN_W);
    localparam logic [FW-1:0]        QNAN      = QNAN_FULL[FW-1:0];
    localparam logic signed [EW-1:0] E_ALL1    = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ONE     = EW'(1);
    localparam logic signed [EW-1:0] E_ZERO    = EW'(0);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   man_ext;
        logic             is_nan;
        logic             is_inf;
        logic             is_zero;
    } fp_unpacked_t;

    // Denormals flush to zero on entry, so a zero exponent always means zero.
    function automatic fp_unpacked_t unpack(input logic [FW-1:0] x);
        fp_unpacked_t u;
        u.sign    = x[FW-1];
        u.exp     = x[FW-2:MAN_W];
        u.is_zero = (u.exp == '0);
        u.is_inf  = (u.exp == '1) && (x[MAN_W-1:0] == '0);
        u.is_nan  = (u.exp == '1) && (x[MAN_W-1:0] != '0);
        u.man_ext = u.is_zero ? '0 : {1'b1, x[MAN_W-1:0]};
        return u;
    endfunction

    logic load1_s, load2_s, load3_s;

    logic             s1_v_q, s1_sign_q, s1_sub_q;
    logic [TAG_W-1:0] s1_tag_q;
    sp_kind_e         s1_kind_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [W-1:0]     s1_mx_q, s1_my_q;

    logic             s2_v_q, s2_sign_q;
    logic [TAG_W-1:0] s2_tag_q;
    sp_kind_e         s2_kind_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [W:0]       s2_sum_q;

    logic             out_valid_q;
    logic [FW-1:0]    r_q;
    logic [TAG_W-1:0] tag_q;
    fp_flags_t        flags_q;

    assign load3_s    = !out_valid_q || out_ready_i;
    assign load2_s    = !s2_v_q || load3_s;
    assign load1_s    = !s1_v_q || load2_s;
    assign in_ready_o = load1_s;

    // ---------------- S1: classify, swap, align ----------------
    fp_unpacked_t     ua_s, ub_s;
    logic             a_ge_b_s, eff_sub_s, x_sign_s, y_lost_s;
    logic [EXP_W-1:0] x_exp_s, y_exp_s, shift_s;
    logic [MAN_W:0]   x_man_s, y_man_s;
    logic [W-1:0]     y_full_s, y_shr_s;
    logic [W-1:0]     s1_mx_d, s1_my_d;
    sp_kind_e         s1_kind_d;
    logic             s1_sign_d;

    // Operand swap and right alignment of the smaller magnitude, keeping G/R/sticky.
    always_comb begin
        ua_s      = unpack(a_i);
        ub_s      = unpack(b_i);
        ub_s.sign = b_i[FW-1] ^ op_i;
        eff_sub_s = ua_s.sign ^ ub_s.sign;
        a_ge_b_s  = {ua_s.exp, ua_s.man_ext} >= {ub_s.exp, ub_s.man_ext};
        if (a_ge_b_s) begin
            x_sign_s = ua_s.sign;
            x_exp_s  = ua_s.exp;
            x_man_s  = ua_s.man_ext;
            y_exp_s  = ub_s.exp;
            y_man_s  = ub_s.man_ext;
        end else begin
            x_sign_s = ub_s.sign;
            x_exp_s  = ub_s.exp;
            x_man_s  = ub_s.man_ext;
            y_exp_s  = ua_s.exp;
            y_man_s  = ua_s.man_ext;
        end
        shift_s  = x_exp_s - y_exp_s;
        y_full_s = {y_man_s, 3'b000};
        y_shr_s  = y_full_s >> shift_s;
        y_lost_s = |(y_full_s & ~({W{1'b1}} << shift_s));
        s1_mx_d  = {x_man_s, 3'b000};
        s1_my_d  = {y_shr_s[W-1:1], y_shr_s[0] | y_lost_s};

        if (ua_s.is_nan || ub_s.is_nan) begin
            s1_kind_d = SP_NAN;
            s1_sign_d = 1'b0;
        end else if (ua_s.is_inf && ub_s.is_inf) begin
            s1_kind_d = eff_sub_s ? SP_NAN : SP_INF;
            s1_sign_d = ua_s.sign;
        end else if (ua_s.is_inf) begin
            s1_kind_d = SP_INF;
            s1_sign_d = ua_s.sign;
        end else if (ub_s.is_inf) begin
            s1_kind_d = SP_INF;
            s1_sign_d = ub_s.sign;
        end else if (ua_s.is_zero && ub_s.is_zero) begin
            s1_kind_d = SP_ZERO;
            s1_sign_d = ua_s.sign & ub_s.sign;
        end else begin
            s1_kind_d = SP_NONE;
            s1_sign_d = x_sign_s;
        end
    end

    // S1 pipeline register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_v_q    <= 1'b0;
            s1_tag_q  <= '0;
            s1_kind_q <= SP_NONE;
            s1_sign_q <= 1'b0;
            s1_sub_q  <= 1'b0;
            s1_exp_q  <= '0;
            s1_mx_q   <= '0;
            s1_my_q   <= '0;
        end else if (load1_s) begin
            s1_v_q    <= in_valid_i;
            s1_tag_q  <= in_tag_i;
            s1_kind_q <= s1_kind_d;
            s1_sign_q <= s1_sign_d;
            s1_sub_q  <= eff_sub_s;
            s1_exp_q  <= x_exp_s;
            s1_mx_q   <= s1_mx_d;
            s1_my_q   <= s1_my_d;
        end
    end

    // ---------------- S2: magnitude add/subtract ----------------
    logic [W:0] s2_sum_d;

    // |X| >= |Y| after the swap, so the difference never goes negative.
    always_comb begin
        if (s1_sub_q) begin
            s2_sum_d = {1'b0, s1_mx_q} - {1'b0, s1_my_q};
        end else begin
            s2_sum_d = {1'b0, s1_mx_q} + {1'b0, s1_my_q};
        end
    end

    // S2 pipeline register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_v_q    <= 1'b0;
            s2_tag_q  <= '0;
            s2_kind_q <= SP_NONE;
            s2_sign_q <= 1'b0;
            s2_exp_q  <= '0;
            s2_sum_q  <= '0;
        end else if (load2_s) begin
            s2_v_q    <= s1_v_q;
            s2_tag_q  <= s1_tag_q;
            s2_kind_q <= s1_kind_q;
            s2_sign_q <= s1_sign_q;
            s2_exp_q  <= s1_exp_q;
            s2_sum_q  <= s2_sum_d;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [LZW-1:0]         lz_s;
    logic [W-1:0]           norm_s;
    logic signed [EW-1:0]   exp_ext_s, lz_ext_s, e_norm_s, e_fin_s;
    logic                   round_up_s, inx_s;
    logic [MAN_W+1:0]       mant_r_s;
    logic [MAN_W-1:0]       man_fin_s;
    logic [FW-1:0]          res_d;
    fp_flags_t              flags_d;

    fp_lzc #(.WIDTH(W), .CW(LZW)) u_lzc (
        .data_i  (s2_sum_q[W-1:0]),
        .count_o (lz_s)
    );

    // Normalisation, RNE on guard/round/sticky, then range checks and special forwarding.
    always_comb begin
        exp_ext_s = $signed({{(EW-EXP_W){1'b0}}, s2_exp_q});
        lz_ext_s  = $signed({{(EW-LZW){1'b0}}, lz_s});
        if (s2_sum_q[W]) begin
            norm_s   = {s2_sum_q[W:2], s2_sum_q[1] | s2_sum_q[0]};
            e_norm_s = exp_ext_s + E_ONE;
        end else begin
            norm_s   = s2_sum_q[W-1:0] << lz_s;
            e_norm_s = exp_ext_s - lz_ext_s;
        end
        round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        inx_s      = |norm_s[2:0];
        mant_r_s   = {1'b0, norm_s[W-1:3]} + {{(MAN_W+1){1'b0}}, round_up_s};
        if (mant_r_s[MAN_W+1]) begin
            e_fin_s   = e_norm_s + E_ONE;
            man_fin_s = mant_r_s[MAN_W:1];
        end else begin
            e_fin_s   = e_norm_s;
            man_fin_s = mant_r_s[MAN_W-1:0];
        end

        res_d   = '0;
        flags_d = '0;
        case (s2_kind_q)
            SP_NAN: begin
                res_d       = QNAN;
                flags_d.inv = 1'b1;
            end
            SP_INF: begin
                res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
            SP_ZERO: begin
                res_d = {s2_sign_q, {(FW-1){1'b0}}};
            end
            SP_NONE: begin
                if (s2_sum_q == '0) begin
                    res_d = '0;
                end else if (e_fin_s >= E_ALL1) begin
                    res_d       = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_d.ovf = 1'b1;
                    flags_d.inx = 1'b1;
                end else if (e_fin_s <= E_ZERO) begin
                    res_d       = {s2_sign_q, {(FW-1){1'b0}}};
                    flags_d.unf = 1'b1;
                    flags_d.inx = 1'b1;
                end else begin
                    res_d       = {s2_sign_q, e_fin_s[EXP_W-1:0], man_fin_s};
                    flags_d.inx = inx_s;
                end
            end
            default: begin
                res_d = '0;
            end
        endcase
    end

    // Output register; contents only change when the consumer can take a new result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            r_q         <= '0;
            tag_q       <= '0;
            flags_q     <= '0;
        end else if (load3_s) begin
            out_valid_q <= s2_v_q;
            if (s2_v_q) begin
                r_q     <= res_d;
                tag_q   <= s2_tag_q;
                flags_q <= flags_d;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign r_o         = r_q;
    assign out_tag_o   = tag_q;
    assign overflow_o  = flags_q.ovf;
    assign underflow_o = flags_q.unf;
    assign inexact_o   = flags_q.inx;
    assign invalid_o   = flags_q.inv;

endmodule
